dac_ramp_sequencer: RTL and testbench

//  Run/stop sequencer for one DAC channel's signal composer. Drives the composer's

---
 rtl/dac_ramp_sequencer.sv | 142 ++++++++++++++
 tb/tb_dac_ramp_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_ramp_sequencer.sv
// rtl/dac_ramp_sequencer.sv - run/stop amplitude ramp sequencer for one DAC channel
module dac_ramp_sequencer #(
  parameter logic [15:0] UNITY = 16'h8000
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        start,
  input  logic        stop,
  input  logic        abort,
  input  logic [15:0] ramp_step,
  input  logic        cfg_dyn_offset_disable,
  input  logic [15:0] signal_in,
  input  logic        signal_in_valid,
  output logic        disable_dac_out,
  output logic        dyn_offset_disable_out,
  output logic [15:0] signal_out,
  output logic        signal_out_valid,
  output logic [1:0]  state,
  output logic        ramp_up_done,
  output logic        ramp_down_done
);
  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_RAMP_UP   = 2'b01,
    S_RUN       = 2'b10,
    S_RAMP_DOWN = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [15:0]        r_factor;
  logic [15:0]        w_factor_next;
  logic               w_up_done;
  logic               w_down_done;
  logic [16:0]        w_sum;
  logic [15:0]        w_up_factor;
  logic [15:0]        w_down_factor;
  logic signed [32:0] w_in_ext;
  logic signed [32:0] w_fac_ext;
  logic signed [32:0] r_prod;
  logic [15:0]        r_out;
  logic [1:0]         r_valid;
  logic               r_up_done;
  logic               r_down_done;
  logic               r_dis_dac;
  logic               r_dyn_dis;
  logic               w_unused_prod;

  // 17-bit sum so a large step cannot wrap past UNITY back to a small factor
  assign w_sum         = {1'b0, r_factor} + {1'b0, ramp_step};
  assign w_up_factor   = (ramp_step == 16'd0 || w_sum >= {1'b0, UNITY}) ? UNITY : w_sum[15:0];
  assign w_down_factor = (ramp_step == 16'd0 || r_factor <= ramp_step) ? 16'd0
                                                                      : r_factor - ramp_step;

  always_comb begin
    w_state_next  = r_state;
    w_factor_next = r_factor;
    w_up_done     = 1'b0;
    w_down_done   = 1'b0;
    if (abort) begin
      w_state_next  = S_IDLE;
      w_factor_next = 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_factor_next = 16'd0;
          if (start && !stop) w_state_next = S_RAMP_UP;
        end
        S_RAMP_UP: begin
          if (stop) begin
            w_state_next = S_RAMP_DOWN;
          end else begin
            w_factor_next = w_up_factor;
            if (w_up_factor == UNITY) begin
              w_state_next = S_RUN;
              w_up_done    = 1'b1;
            end
          end
        end
        S_RUN: begin
          w_factor_next = UNITY;
          if (stop) w_state_next = S_RAMP_DOWN;
        end
        S_RAMP_DOWN: begin
          w_factor_next = w_down_factor;
          if (w_down_factor == 16'd0) begin
            w_state_next = S_IDLE;
            w_down_done  = 1'b1;
          end
        end
        default: begin
          w_state_next  = S_IDLE;
          w_factor_next = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_factor    <= 16'd0;
      r_up_done   <= 1'b0;
      r_down_done <= 1'b0;
      r_dis_dac   <= 1'b1;
      r_dyn_dis   <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_factor    <= w_factor_next;
      r_up_done   <= w_up_done;
      r_down_done <= w_down_done;
      r_dis_dac   <= (w_state_next == S_IDLE);
      r_dyn_dis   <= cfg_dyn_offset_disable | (w_state_next != S_RUN);
    end
  end

  // factor is unsigned Q1.15, so it enters the signed multiply zero-extended
  assign w_in_ext  = {{17{signal_in[15]}}, signal_in};
  assign w_fac_ext = {17'd0, r_factor};

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_prod  <= '0;
      r_out   <= 16'd0;
      r_valid <= 2'b00;
    end else begin
      r_prod  <= w_in_ext * w_fac_ext;
      r_out   <= r_prod[30:15];
      r_valid <= {r_valid[0], signal_in_valid};
    end
  end

  assign w_unused_prod = ^{r_prod[32:31], r_prod[14:0]};

  assign disable_dac_out        = r_dis_dac;
  assign dyn_offset_disable_out = r_dyn_dis;
  assign signal_out             = r_out;
  assign signal_out_valid       = r_valid[1];
  assign state                  = r_state;
  assign ramp_up_done           = r_up_done;
  assign ramp_down_done         = r_down_done;
endmodule

// File: tb/tb_dac_ramp_sequencer.sv
// tb/tb_dac_ramp_sequencer.sv - randomized bench with arithmetic reference model for dac_ramp_sequencer
module tb_dac_ramp_sequencer;
  localparam int U = 32768;

  logic        clk = 1'b0;
  logic        aresetn = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] ramp_step = 16'd0;
  logic        cfg = 1'b0;
  logic [15:0] signal_in = 16'd0;
  logic        signal_in_valid = 1'b0;
  logic        disable_dac_out;
  logic        dyn_offset_disable_out;
  logic [15:0] signal_out;
  logic        signal_out_valid;
  logic [1:0]  state;
  logic        ramp_up_done;
  logic        ramp_down_done;

  dac_ramp_sequencer dut (
    .clk                    (clk),
    .aresetn                (aresetn),
    .start                  (start),
    .stop                   (stop),
    .abort                  (abort),
    .ramp_step              (ramp_step),
    .cfg_dyn_offset_disable (cfg),
    .signal_in              (signal_in),
    .signal_in_valid        (signal_in_valid),
    .disable_dac_out        (disable_dac_out),
    .dyn_offset_disable_out (dyn_offset_disable_out),
    .signal_out             (signal_out),
    .signal_out_valid       (signal_out_valid),
    .state                  (state),
    .ramp_up_done           (ramp_up_done),
    .ramp_down_done         (ramp_down_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: state as 0..3, factor as a plain integer, output as floor(in*factor/2^15)
  int          m_state = 0;
  int          m_factor = 0;
  int          m_pin = 0;
  int          m_pfac = 0;
  int          ns;
  int          nf;
  longint      prod;
  logic [15:0] m_out = 16'd0;
  logic        m_v1 = 1'b0, m_v2 = 1'b0, m_up = 1'b0, m_down = 1'b0;
  logic        m_dis = 1'b1, m_dyn = 1'b1;

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_state = 0; m_factor = 0; m_pin = 0; m_pfac = 0; m_out = 16'd0;
      m_v1 = 1'b0; m_v2 = 1'b0; m_up = 1'b0; m_down = 1'b0; m_dis = 1'b1; m_dyn = 1'b1;
    end else begin
      prod  = longint'(m_pin) * longint'(m_pfac);
      m_out = 16'(prod >>> 15);
      m_v2  = m_v1;
      m_v1  = signal_in_valid;
      m_pin = int'($signed(signal_in));
      m_pfac = m_factor;
      ns = m_state; nf = m_factor; m_up = 1'b0; m_down = 1'b0;
      if (abort) begin
        ns = 0; nf = 0;
      end else if (m_state == 0) begin
        nf = 0;
        if (start && !stop) ns = 1;
      end else if (m_state == 1) begin
        if (stop) ns = 3;
        else begin
          nf = (ramp_step == 0) ? U : ((m_factor + ramp_step > U) ? U : m_factor + ramp_step);
          if (nf == U) begin ns = 2; m_up = 1'b1; end
        end
      end else if (m_state == 2) begin
        nf = U;
        if (stop) ns = 3;
      end else begin
        nf = (ramp_step == 0 || m_factor <= ramp_step) ? 0 : m_factor - ramp_step;
        if (nf == 0) begin ns = 0; m_down = 1'b1; end
      end
      m_state = ns;
      m_factor = nf;
      m_dis = (ns == 0);
      m_dyn = cfg | (ns != 2);
    end
  end

  always @(negedge clk) begin
    chk("state", 32'(state), 32'(m_state));
    chk("signal_out", 32'(signal_out), 32'(m_out));
    chk("signal_out_valid", 32'(signal_out_valid), 32'(m_v2));
    chk("ramp_up_done", 32'(ramp_up_done), 32'(m_up));
    chk("ramp_down_done", 32'(ramp_down_done), 32'(m_down));
    chk("disable_dac_out", 32'(disable_dac_out), 32'(m_dis));
    chk("dyn_offset_disable_out", 32'(dyn_offset_disable_out), 32'(m_dyn));
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #1 aresetn = 1'b0;
    cyc(3);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_out", 32'(signal_out), 32'h0);
    chk("rst_dis_dac", 32'(disable_dac_out), 32'h1);
    chk("rst_dyn_dis", 32'(dyn_offset_disable_out), 32'h1);
    aresetn = 1'b1;

    // ramp-up with step 2000, full-scale positive input
    signal_in = 16'h7FFF; signal_in_valid = 1'b1; ramp_step = 16'h2000;
    cyc(2);
    start = 1'b1;
    cyc(1); start = 1'b0;
    chk("up_state_ru", 32'(state), 32'h1);
    cyc(3);
    chk("up_out_1fff", 32'(signal_out), 32'h1FFF);
    cyc(1);
    chk("up_out_3fff", 32'(signal_out), 32'h3FFF);
    chk("up_state_run", 32'(state), 32'h2);
    chk("up_done_pulse", 32'(ramp_up_done), 32'h1);
    cyc(1);
    chk("up_out_5fff", 32'(signal_out), 32'h5FFF);
    chk("up_done_clear", 32'(ramp_up_done), 32'h0);
    cyc(1);
    chk("up_out_7fff", 32'(signal_out), 32'h7FFF);

    // asynchronous reset while running
    signal_in = 16'h4000;
    cyc(2);
    #2 aresetn = 1'b0;
    #1;
    chk("async_out", 32'(signal_out), 32'h0);
    chk("async_dis_dac", 32'(disable_dac_out), 32'h1);
    chk("async_state", 32'(state), 32'h0);
    cyc(1); aresetn = 1'b1;
    signal_in = 16'h7FFF;

    // clamp: step 3000 reaches UNITY after three increments
    ramp_step = 16'h3000;
    cyc(1); start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(2);
    chk("clamp_state_ru", 32'(state), 32'h1);
    cyc(1);
    chk("clamp_state_run", 32'(state), 32'h2);
    chk("clamp_up_done", 32'(ramp_up_done), 32'h1);
    cyc(3);
    chk("clamp_out_unity", 32'(signal_out), 32'h7FFF);
    abort = 1'b1;
    cyc(1); abort = 1'b0;
    cyc(3);

    // stop mid-ramp at factor 3000
    ramp_step = 16'h1000;
    start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(3);
    stop = 1'b1;
    cyc(1); stop = 1'b0;
    chk("stop_state_rd", 32'(state), 32'h3);
    cyc(2);
    chk("stop_still_rd", 32'(state), 32'h3);
    cyc(1);
    chk("stop_state_idle", 32'(state), 32'h0);
    chk("stop_down_done", 32'(ramp_down_done), 32'h1);
    chk("stop_dis_dac", 32'(disable_dac_out), 32'h1);
    cyc(2);

    // abort in RUN with most-negative input
    ramp_step = 16'h4000;
    start = 1'b1;
    cyc(1); start = 1'b0;
    signal_in = 16'h8000;
    cyc(4);
    abort = 1'b1;
    cyc(1); abort = 1'b0;
    chk("abort_state", 32'(state), 32'h0);
    chk("abort_no_down", 32'(ramp_down_done), 32'h0);
    chk("abort_out_neg", 32'(signal_out), 32'h8000);
    cyc(1);
    chk("abort_out_neg2", 32'(signal_out), 32'h8000);
    cyc(1);
    chk("abort_out_zero", 32'(signal_out), 32'h0);

    // step 0: instant ramps, and start+stop together ignored
    ramp_step = 16'h0000; signal_in = 16'h1234;
    start = 1'b1;
    cyc(1); start = 1'b0;
    chk("z_state_ru", 32'(state), 32'h1);
    cyc(1);
    chk("z_state_run", 32'(state), 32'h2);
    chk("z_up_done", 32'(ramp_up_done), 32'h1);
    stop = 1'b1;
    cyc(1); stop = 1'b0;
    chk("z_state_rd", 32'(state), 32'h3);
    cyc(1);
    chk("z_state_idle", 32'(state), 32'h0);
    chk("z_down_done", 32'(ramp_down_done), 32'h1);
    start = 1'b1; stop = 1'b1;
    cyc(1); start = 1'b0; stop = 1'b0;
    chk("z_both_idle", 32'(state), 32'h0);
    cyc(1);
    chk("z_both_idle2", 32'(state), 32'h0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      abort = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 4))
          0: ramp_step = 16'h0000;
          1: ramp_step = 16'($urandom);
          2: ramp_step = 16'($urandom_range(16'h0800, 16'h4000));
          3: ramp_step = 16'hFFFF;
          default: ramp_step = 16'h8000;
        endcase
      end
      if ($urandom_range(0, 31) == 0) cfg = ~cfg;
      signal_in = 16'($urandom);
      signal_in_valid = ($urandom_range(0, 3) != 0);
      if (c == 2000) begin
        #2 aresetn = 1'b0;
        #2 aresetn = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0; abort = 1'b0;
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
